// File: rtl/cmd_packer.sv
// Command packer: validates one layer descriptor per handshake and serialises it
// into a 6-word burst written sequentially into the command memory region.
module cmd_packer #(
  parameter int unsigned BURST_LEN = 6,
  parameter int unsigned CMD_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [2:0]  op_type,
  input  logic        padding,
  input  logic [3:0]  stride,
  input  logic [3:0]  kernel,
  input  logic [15:0] i_channel,
  input  logic [15:0] o_channel,
  input  logic [7:0]  i_side,
  input  logic [7:0]  o_side,
  input  logic [31:0] weight_start_addr,
  input  logic [31:0] data_start_addr,
  input  logic [31:0] result_start_addr,
  output logic        wr_en,
  output logic [6:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_full,
  output logic [6:0]  cmd_size,
  output logic        busy,
  output logic        err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_EMIT  = 1'b1;
  localparam logic [2:0] LAST_IDX = 3'(BURST_LEN - 1);

  logic [0:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [6:0]       wr_ptr_q, wr_ptr_d;
  logic [6:0]       cmd_size_q, cmd_size_d;
  logic             err_q, err_d;
  logic [5:0][31:0] words_q, words_d;

  logic             op_ok;
  logic             room_ok;
  logic             desc_ok;
  logic [7:0]       kernel_size;
  logic [7:0]       stride2;
  logic [5:0][31:0] new_words;
  logic [31:0]      word_sel;

  always_comb begin
    op_ok       = (op_type == 3'b001) || (op_type == 3'b100) || (op_type == 3'b101);
    room_ok     = ({1'b0, wr_ptr_q} + 8'(BURST_LEN)) <= 8'(CMD_DEPTH);
    desc_ok     = op_ok && (kernel != 4'd0) && (stride != 4'd0) && (stride <= kernel) && room_ok;
    kernel_size = 8'(kernel) * 8'(kernel);
    stride2     = 8'(kernel) * 8'(stride);
    new_words[0] = {8'h00, 4'h0, kernel, 4'h0, stride, 3'b000, padding, 1'b0, op_type};
    new_words[1] = {o_channel, i_channel};
    new_words[2] = {stride2, kernel_size, o_side, i_side};
    new_words[3] = weight_start_addr;
    new_words[4] = data_start_addr;
    new_words[5] = result_start_addr;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wr_ptr_d   = wr_ptr_q;
    cmd_size_d = cmd_size_q;
    err_d      = err_q;
    words_d    = words_q;
    if (flush) begin
      // Abandons any burst in flight; words already written stay in memory.
      state_d    = ST_IDLE;
      idx_d      = '0;
      wr_ptr_d   = '0;
      cmd_size_d = '0;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (desc_valid) begin
            if (desc_ok) begin
              words_d = new_words;
              state_d = ST_EMIT;
              idx_d   = '0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: begin
          if (!wr_full) begin
            wr_ptr_d = wr_ptr_q + 7'd1;
            if (idx_q == LAST_IDX) begin
              idx_d      = '0;
              state_d    = ST_IDLE;
              cmd_size_d = cmd_size_q + 7'd1;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      wr_ptr_q   <= '0;
      cmd_size_q <= '0;
      err_q      <= 1'b0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_ptr_q   <= wr_ptr_d;
      cmd_size_q <= cmd_size_d;
      err_q      <= err_d;
      words_q    <= words_d;
    end
  end

  always_comb begin
    case (idx_q)
      3'd0:    word_sel = words_q[0];
      3'd1:    word_sel = words_q[1];
      3'd2:    word_sel = words_q[2];
      3'd3:    word_sel = words_q[3];
      3'd4:    word_sel = words_q[4];
      3'd5:    word_sel = words_q[5];
      default: word_sel = '0;
    endcase
  end

  assign busy       = (state_q == ST_EMIT);
  assign desc_ready = (state_q == ST_IDLE) && !flush && !rst;
  // Flush suppresses the write in its own cycle so the abandoned burst stops immediately.
  assign wr_en      = busy && !wr_full && !flush;
  assign wr_addr    = wr_ptr_q;
  assign wr_data    = busy ? word_sel : '0;
  assign cmd_size   = cmd_size_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cmd_packer.sv
// Directed bench for cmd_packer: logs every memory write and compares bursts,
// timing, backpressure, rejects, capacity and flush against hand-computed values.
module tb_cmd_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        desc_valid;
  logic        desc_ready;
  logic [2:0]  op_type;
  logic        padding;
  logic [3:0]  stride;
  logic [3:0]  kernel;
  logic [15:0] i_channel, o_channel;
  logic [7:0]  i_side, o_side;
  logic [31:0] weight_start_addr, data_start_addr, result_start_addr;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_full;
  logic [6:0]  cmd_size;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [6:0]  la[$];
  logic [31:0] ld[$];
  int          lc[$];

  logic [31:0] exp_conv [6];

  cmd_packer #(.BURST_LEN(6), .CMD_DEPTH(128)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .op_type(op_type), .padding(padding), .stride(stride), .kernel(kernel),
    .i_channel(i_channel), .o_channel(o_channel),
    .i_side(i_side), .o_side(o_side),
    .weight_start_addr(weight_start_addr), .data_start_addr(data_start_addr),
    .result_start_addr(result_start_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_full(wr_full),
    .cmd_size(cmd_size), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      la.push_back(wr_addr);
      ld.push_back(wr_data);
      lc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic log_clear();
    la.delete();
    ld.delete();
    lc.delete();
  endtask

  task automatic set_conv();
    op_type = 3'd1; padding = 1'b1; stride = 4'd1; kernel = 4'd3;
    i_channel = 16'd3; o_channel = 16'd64; i_side = 8'd227; o_side = 8'd113;
    weight_start_addr = 32'h0000_1000;
    data_start_addr   = 32'h000A_0000;
    result_start_addr = 32'h000C_0000;
  endtask

  // Called at #1 after a rising edge; returns the accept cycle number.
  task automatic send(output int t);
    desc_valid = 1'b1;
    t = cyc;
    step();
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) check("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic reject_case(input string tag, input logic [2:0] op, input logic [3:0] s,
                             input logic [3:0] k);
    int t;
    do_flush();
    set_conv();
    send(t);
    wait_idle();
    check({tag, "_pre_err"}, {31'b0, err}, 32'd0);
    check({tag, "_pre_size"}, {25'b0, cmd_size}, 32'd1);
    log_clear();
    op_type = op; stride = s; kernel = k;
    send(t);
    repeat (3) step();
    check({tag, "_err"}, {31'b0, err}, 32'd1);
    check({tag, "_size"}, {25'b0, cmd_size}, 32'd1);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_nowr"}, la.size(), 32'd0);
  endtask

  initial begin
    int t;
    exp_conv[0] = 32'h0003_0111; exp_conv[1] = 32'h0040_0003; exp_conv[2] = 32'h0309_71E3;
    exp_conv[3] = 32'h0000_1000; exp_conv[4] = 32'h000A_0000; exp_conv[5] = 32'h000C_0000;
    rst = 1'b1; flush = 1'b0; desc_valid = 1'b0; wr_full = 1'b0;
    set_conv();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'b0, desc_ready}, 32'd1);
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_size", {25'b0, cmd_size}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_addr", {25'b0, wr_addr}, 32'd0);
    check("rst_data", wr_data, 32'd0);
    step();
    log_clear();

    // Conv descriptor
    send(t);
    wait_idle();
    check("conv_ready_T7", {31'b0, desc_ready}, 32'd1);
    check("conv_ready_cyc", cyc, t + 7);
    check("conv_nwr", la.size(), 32'd6);
    for (int k = 0; k < 6 && k < la.size(); k++) begin
      check("conv_addr", {25'b0, la[k]}, k);
      check("conv_data", ld[k], exp_conv[k]);
      check("conv_cyc", lc[k], t + k + 1);
    end
    check("conv_size", {25'b0, cmd_size}, 32'd1);
    log_clear();

    // Max pool
    op_type = 3'd4; padding = 1'b0; stride = 4'd2; kernel = 4'd3;
    i_side = 8'd56; o_side = 8'd28;
    send(t);
    wait_idle();
    check("pool_nwr", la.size(), 32'd6);
    if (la.size() == 6) begin
      check("pool_addr0", {25'b0, la[0]}, 32'd6);
      check("pool_addr5", {25'b0, la[5]}, 32'd11);
      check("pool_w0", ld[0], 32'h0003_0204);
      check("pool_w2", ld[2], 32'h0609_1C38);
    end
    check("pool_size", {25'b0, cmd_size}, 32'd2);
    log_clear();

    // Backpressure for 3 cycles after W2
    set_conv();
    send(t);
    repeat (3) step();
    wr_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_wr_en", {31'b0, wr_en}, 32'd0);
      check("stall_addr", {25'b0, wr_addr}, 32'd15);
      check("stall_data", wr_data, 32'h0000_1000);
      step();
    end
    wr_full = 1'b0;
    wait_idle();
    check("stall_nwr", la.size(), 32'd6);
    for (int k = 0; k < 6 && k < la.size(); k++) begin
      check("stall_addr_seq", {25'b0, la[k]}, 12 + k);
      check("stall_data_seq", ld[k], exp_conv[k]);
      check("stall_cyc", lc[k], (k < 3) ? (t + k + 1) : (t + k + 4));
    end
    check("stall_size", {25'b0, cmd_size}, 32'd3);
    log_clear();

    // Rejects
    reject_case("rej_op", 3'd2, 4'd1, 4'd3);
    reject_case("rej_stride", 3'd1, 4'd4, 4'd3);
    reject_case("rej_kernel0", 3'd1, 4'd1, 4'd0);

    // Capacity: 22 descriptors
    do_flush();
    log_clear();
    set_conv();
    for (int i = 0; i < 22; i++) begin
      weight_start_addr = 32'h100 + i;
      if (i == 21) check("cap_err_before", {31'b0, err}, 32'd0);
      send(t);
      wait_idle();
    end
    repeat (2) step();
    check("cap_nwr", la.size(), 32'd126);
    for (int k = 0; k < 126 && k < la.size(); k++) check("cap_addr", {25'b0, la[k]}, k);
    for (int i = 0; i < 21 && (6 * i + 3) < la.size(); i++)
      check("cap_w3", ld[6 * i + 3], 32'h100 + i);
    check("cap_size", {25'b0, cmd_size}, 32'd21);
    check("cap_err", {31'b0, err}, 32'd1);
    do_flush();
    log_clear();
    set_conv();
    send(t);
    wait_idle();
    check("cap_reflush_nwr", la.size(), 32'd6);
    if (la.size() > 0) check("cap_reflush_addr", {25'b0, la[0]}, 32'd0);
    check("cap_reflush_size", {25'b0, cmd_size}, 32'd1);
    check("cap_reflush_err", {31'b0, err}, 32'd0);

    // Flush mid-burst at idx 3 with desc_valid
    do_flush();
    log_clear();
    send(t);
    repeat (3) step();
    flush = 1'b1;
    desc_valid = 1'b1;
    @(negedge clk);
    check("fl_ready_low", {31'b0, desc_ready}, 32'd0);
    step();
    flush = 1'b0;
    desc_valid = 1'b0;
    @(negedge clk);
    check("fl_busy", {31'b0, busy}, 32'd0);
    check("fl_size", {25'b0, cmd_size}, 32'd0);
    repeat (4) step();
    begin
      int late;
      late = 0;
      foreach (lc[k]) if (lc[k] > t + 4) late++;
      check("fl_no_more_wr", late, 32'd0);
    end
    log_clear();
    send(t);
    wait_idle();
    check("fl_next_nwr", la.size(), 32'd6);
    if (la.size() > 0) begin
      check("fl_next_addr", {25'b0, la[0]}, 32'd0);
      check("fl_next_data", ld[0], exp_conv[0]);
    end
    check("fl_next_size", {25'b0, cmd_size}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_packer.md
# cmd_packer

Command packer for the accelerator's command region: the encoder side of the command-burst format consumed by the control/status block. It accepts one layer descriptor per handshake, validates it, derives `kernel_size` and `stride2`, and serialises it into a 6-word burst. The burst is written into the command memory starting at word 0, so the host or the init sequencer can build a layer program before asserting `op_en`. It also reports the running command count, which drives the parser's `cmd_size`.

## Interface
- `BURST_LEN`, 6: words per command; fixed, other values unsupported.
- `CMD_DEPTH`, 128: command-region size in 32-bit words.
- `clk` in 1: single clock.
- `rst` in 1: synchronous reset, active-high.
- `flush` in 1: start a new program. Clears the pointer, `cmd_size`, `err` and any burst in flight.
- `desc_valid` in 1 / `desc_ready` out 1: descriptor handshake.
- `op_type` in 3: must be 001 (conv+ReLU), 100 (max pool) or 101 (avg pool).
- `padding` in 1.
- `stride` in 4.
- `kernel` in 4.
- `i_channel` in 16, `o_channel` in 16.
- `i_side` in 8, `o_side` in 8.
- `weight_start_addr` in 32, `data_start_addr` in 32, `result_start_addr` in 32.
- `wr_en` out 1, `wr_addr` out 7, `wr_data` out 32: command-memory write port.
- `wr_full` in 1: sink backpressure. No write takes place in any cycle where it is high.
- `cmd_size` out 7: number of complete commands written since reset or flush.
- `busy` out 1: burst in progress.
- `err` out 1: sticky; set by a rejected descriptor.

## Operation
- States: IDLE, EMIT.
- `desc_ready` = (state==IDLE) & ~`flush`.
- Accept = `desc_valid` & `desc_ready`. On accept, all fields are latched. They are held unchanged until the burst ends.
- Validity check, evaluated combinationally on the accept cycle:
  - `op_type` ∈ {001,100,101};
  - `kernel` != 0;
  - `stride` != 0;
  - `stride` <= `kernel`;
  - `wr_ptr` + 6 <= `CMD_DEPTH`.
- Invalid descriptor: it is consumed and dropped, `err`<=1, state stays IDLE, no write occurs.
- Valid descriptor: state<=EMIT, word index<=0.
- Derived fields, computed at accept:
  - `kernel_size` = `kernel`×`kernel`, 8 bits, max 225;
  - `stride2` = `kernel`×`stride`, 8 bits, max 225.
- Word layout (index 0..5), unused bits zero:
  - W0: [2:0] `op_type`, [4] `padding`, [11:8] `stride`, [23:16] {4'b0,`kernel`}.
  - W1: [15:0] `i_channel`, [31:16] `o_channel`.
  - W2: [7:0] `i_side`, [15:8] `o_side`, [23:16] `kernel_size`, [31:24] `stride2`.
  - W3 = `weight_start_addr`, W4 = `data_start_addr`, W5 = `result_start_addr`.
- EMIT:
  - `wr_en` = ~`wr_full`; `wr_data` = W[idx]; `wr_addr` = `wr_ptr`.
  - On each write: idx+1, `wr_ptr`+1.
  - On the write of idx 5: `cmd_size`+1, state<=IDLE.
- `busy` = (state==EMIT).
- `flush` has priority over every other event, including mid-burst and simultaneous `desc_valid`. Next cycle:
  - state=IDLE;
  - `wr_ptr`=0, idx=0;
  - `cmd_size`=0, `err`=0.
  - A partially written burst is abandoned; its words remain in memory and are overwritten by the next program.
- Reset: same effect as flush. All outputs 0 except `desc_ready`, which is 1 once `rst` is deasserted.

## Timing
- Accept in cycle T (IDLE). With no backpressure, W0..W5 are written in cycles T+1..T+6, at consecutive `wr_addr`.
- `cmd_size` increments at the edge ending cycle T+6. `desc_ready` is high in T+7.
- Sustained throughput: one command per 7 cycles.
- `wr_full` high for N cycles mid-burst:
  - the burst stretches by exactly N;
  - `wr_data`/`wr_addr` hold;
  - no word is skipped or duplicated.
- `wr_en`, `wr_data` and `wr_addr` must not change while `wr_full` is high.
- `wr_en` is never high in IDLE.
- Capacity: 21 commands, 126 words. A 22nd descriptor is rejected with `err`=1, and `cmd_size` stays 21.

## Test plan
- Reset, then a conv descriptor:
  - inputs: `op_type`=1, pad=1, `stride`=1, `kernel`=3, `i_channel`=3, `o_channel`=64, `i_side`=227, `o_side`=113, addresses 0x1000 / 0xA0000 / 0xC0000;
  - expected writes: addr 0..5 = 0x00030111, 0x00400003, 0x030971E3, 0x00001000, 0x000A0000, 0x000C0000;
  - `cmd_size`=1, cycles T+1..T+6.
- Max pool: `op_type`=4, `kernel`=3, `stride`=2.
  - W0 = 0x00030204, W2[23:16]=9, W2[31:24]=6.
  - Written at addr 6..11; `cmd_size`=2.
- Hold `wr_full` high for 3 cycles after W2:
  - W3 is held and written once;
  - burst ends at T+9;
  - addresses remain contiguous.
- Reject cases, each giving `err`=1, no `wr_en`, unchanged `cmd_size`:
  - `op_type`=2;
  - `stride`=4 with `kernel`=3;
  - `kernel`=0.
- Issue 22 valid descriptors back to back:
  - the first 21 land at addr 0..125 with `cmd_size`=21;
  - the 22nd sets `err` and writes nothing;
  - after `flush`, the next command goes to addr 0 with `cmd_size`=1 and `err`=0.
- Assert `flush` during EMIT at idx 3, with `desc_valid` high in the same cycle:
  - no further writes occur;
  - `desc_ready` stays low that cycle;
  - `cmd_size`=0;
  - the next descriptor is written at addr 0.
